// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 inverse cipher. The key is expanded forward to rk10,
// then one inverse round runs per clock while the key schedule is reversed.
// Optional macro AES_DEC_KEY_CACHE_EN remembers the last key and its rk10 so
// that a repeated key skips the forward expansion.
module aes_decrypt_iterative #(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128,
  parameter int NR      = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] cipher_in,
  input  logic [KEY_W-1:0]   key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plain_out,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, EXPAND, ROUNDS, FINAL, DONE} fsm_t;

  fsm_t               fsm;
  logic [3:0]         rc;
  logic [BLOCK_W-1:0] state_q;
  logic [KEY_W-1:0]   key_q;

  // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] y;
    y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One forward key-schedule step: round key i-1 -> round key i
  function automatic logic [127:0] key_expand_step(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {r, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // One reverse key-schedule step: round key i -> round key i-1
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {r, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  // Row r rotates right by r; byte n = 4*column + row
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared round datapath; FINAL sits at rc=0 so rc+1 selects Rcon[1] there
  logic [127:0] exp_key;
  logic [127:0] inv_key;
  logic [127:0] inv_sr_sb;
  logic [127:0] round_out;
  logic [127:0] final_out;

  assign exp_key   = key_expand_step(key_q, rcon(rc));
  assign inv_key   = inv_key_step(key_q, rcon(rc + 4'd1));
  assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(state_q));
  assign final_out = inv_sr_sb ^ inv_key;
  assign round_out = inv_mix_columns(final_out);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [KEY_W-1:0] cache_key;
  logic [KEY_W-1:0] cache_rk10;
  logic             cache_valid;
  logic             cache_hit;

  assign cache_hit = cache_valid && (key_in == cache_key);
`endif

  // Control FSM with registered handshake outputs and the round datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm       <= IDLE;
      rc        <= 4'd0;
      state_q   <= '0;
      key_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plain_out <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key   <= '0;
      cache_rk10  <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              key_q   <= cache_rk10;
              state_q <= cipher_in ^ cache_rk10;
              rc      <= 4'(NR - 1);
              fsm     <= ROUNDS;
            end else begin
              cache_key   <= key_in;
              cache_valid <= 1'b0;
              key_q       <= key_in;
              state_q     <= cipher_in;
              rc          <= 4'd1;
              fsm         <= EXPAND;
            end
`else
            key_q   <= key_in;
            state_q <= cipher_in;
            rc      <= 4'd1;
            fsm     <= EXPAND;
`endif
          end
        end
        EXPAND: begin
          key_q <= exp_key;
          if (rc == 4'(NR)) begin
            state_q <= state_q ^ exp_key;
            rc      <= 4'(NR - 1);
            fsm     <= ROUNDS;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_rk10  <= exp_key;
            cache_valid <= 1'b1;
`endif
          end else begin
            rc <= rc + 4'd1;
          end
        end
        ROUNDS: begin
          key_q   <= inv_key;
          state_q <= round_out;
          rc      <= rc - 4'd1;
          if (rc == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          key_q   <= inv_key;
          state_q <= final_out;
          fsm     <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            plain_out <= state_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Self-checking bench for aes_decrypt_iterative: FIPS-197 vectors plus random
// vectors against a table-driven byte-level AES-128 decryption model.
module tb_aes_decrypt_iterative;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_out;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0] exp_t [256];
  logic [7:0] log_t [256];
  logic [7:0] sbox_t [256];
  logic [7:0] inv_sbox_t [256];

  bit           cache_ok;
  logic [127:0] cache_key_m;

  aes_decrypt_iterative dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cipher_in(cipher_in),
    .key_in   (key_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plain_out(plain_out),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] xtime(input logic [7:0] p);
    return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  // Log/antilog tables over generator 3, then S-box via inverse and bitwise affine map
  task automatic build_tables();
    logic [7:0] p, x, s;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i[7:0];
      p = p ^ xtime(p);
    end
    exp_t[255] = exp_t[0];
    log_t[0] = 8'h00;
    for (int a = 0; a < 256; a++) begin
      x = (a == 0) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
      s = 8'h00;
      for (int b = 0; b < 8; b++)
        s[b] = x[b] ^ x[(b+4)%8] ^ x[(b+5)%8] ^ x[(b+6)%8] ^ x[(b+7)%8];
      s = s ^ 8'h63;
      sbox_t[a] = s;
      inv_sbox_t[s] = a[7:0];
    end
  endtask

  // Textbook AES-128 decryption: full key expansion, then the inverse cipher on a byte array
  function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rcv;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rcv, 24'h0};
        rcv = xtime(rcv);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) begin
      tmp = w[40 + n/4];
      s[n] = ct[127-8*n -: 8] ^ tmp[31-8*(n%4) -: 8];
    end
    for (int round = 9; round >= 0; round--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = inv_sbox_t[s[4*((c-r+4)%4)+r]];
      for (int n = 0; n < 16; n++) begin
        tmp = w[4*round + n/4];
        t[n] = t[n] ^ tmp[31-8*(n%4) -: 8];
      end
      if (round > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end else begin
        for (int n = 0; n < 16; n++) s[n] = t[n];
      end
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Edges from acceptance to out_valid: 11 on a key-cache hit, else 21
  function automatic int expected_latency(input logic [127:0] key);
    return (CACHE_EN && cache_ok && key == cache_key_m) ? 11 : 21;
  endfunction

  task automatic record_key(input logic [127:0] key);
    if (!(cache_ok && key == cache_key_m)) begin
      cache_key_m = key;
      cache_ok    = 1'b1;
    end
  endtask

  // Present one pair at a negedge; it is accepted on the following posedge
  task automatic issue(input logic [127:0] key, input logic [127:0] ct);
    @(negedge clock);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clock);
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL issue_ready: in_ready=%b, want 1", in_ready);
    end
    key_in    = key;
    cipher_in = ct;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid, optionally throwing junk at the input meanwhile
  task automatic await_result(input bit noisy, output logic [127:0] pt, output int lat);
    lat = 0;
    pt  = '0;
    while (lat < 64) begin
      @(posedge clock);
      lat++;
      #1;
      if (out_valid) break;
      if (noisy) begin
        in_valid  = 1'($urandom);
        cipher_in = rand128();
        key_in    = rand128();
      end
    end
    in_valid = 1'b0;
    if (out_valid) pt = plain_out;
    else begin
      vectors++; miscompares++;
      $display("[TB] FAIL await_timeout: out_valid=%b after %0d edges, want 1", out_valid, lat);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cipher_in = '0;
    key_in    = '0;
    reset_n   = 1'b0;
    cache_ok  = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (plain_out !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_plain_out: got %h want 0", plain_out); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fips(input string name, input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] want);
    logic [127:0] pt;
    int lat, want_lat;
    want_lat = expected_latency(key);
    issue(key, ct);
    record_key(key);
    await_result(1'b0, pt, lat);
    vectors++;
    if (pt !== want) begin miscompares++; $display("[TB] FAIL %s_plain: got %h want %h", name, pt, want); end
    vectors++;
    if (lat != want_lat) begin miscompares++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, want_lat); end
    release_out();
    vectors++;
    if ({out_valid, in_ready, plain_out} !== {1'b0, 1'b1, want}) begin
      miscompares++;
      $display("[TB] FAIL %s_handshake: out_valid=%b in_ready=%b plain_out=%h want 0 1 %h",
               name, out_valid, in_ready, plain_out, want);
    end
  endtask

  task automatic test_random();
    logic [127:0] key, ct, pt, want;
    int lat, want_lat;
    for (int i = 0; i < 6; i++) begin
      key = rand128();
      ct  = rand128();
      want = model_decrypt(key, ct);
      want_lat = expected_latency(key);
      issue(key, ct);
      record_key(key);
      await_result(1'b0, pt, lat);
      vectors++;
      if (pt !== want || lat != want_lat) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: got %h lat %0d want %h lat %0d", i, pt, lat, want, want_lat);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt;
    int lat, want_lat;
    want_lat = expected_latency(C1_KEY);
    issue(C1_KEY, C1_CT);
    record_key(C1_KEY);
    await_result(1'b0, pt, lat);
    vectors++;
    if (pt !== C1_PT || lat != want_lat) begin
      miscompares++;
      $display("[TB] FAIL bp_result: got %h lat %0d want %h lat %0d", pt, lat, C1_PT, want_lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      vectors++;
      if ({out_valid, in_ready, plain_out} !== {1'b1, 1'b0, C1_PT}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold_%0d: out_valid=%b in_ready=%b plain_out=%h want 1 0 %h",
                 i, out_valid, in_ready, plain_out, C1_PT);
      end
    end
    release_out();
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL bp_release: out_valid/in_ready/busy=%b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] key;
    key = rand128();
    issue(key, rand128());
    record_key(key);
    repeat (14) @(posedge clock);
    #2;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midrun_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL midrun_abort: out_valid/in_ready/busy=%b want 010", {out_valid, in_ready, busy});
    end
    cache_ok = 1'b0;
    #2 reset_n = 1'b1;
    test_fips("midrun_c1", C1_KEY, C1_CT, C1_PT);
  endtask

  task automatic test_ignored_input();
    logic [127:0] pt;
    int lat, want_lat;
    want_lat = expected_latency(C1_KEY);
    issue(C1_KEY, C1_CT);
    record_key(C1_KEY);
    await_result(1'b1, pt, lat);
    vectors++;
    if (pt !== C1_PT || lat != want_lat) begin
      miscompares++;
      $display("[TB] FAIL ignored_input: got %h lat %0d want %h lat %0d", pt, lat, C1_PT, want_lat);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [127:0] key_a, key_b, ct_b, pt, want;
    int lat, want_lat;
    key_a = rand128();
    issue(key_a, rand128());
    record_key(key_a);
    await_result(1'b0, pt, lat);
    key_b = rand128();
    ct_b  = rand128();
    want  = model_decrypt(key_b, ct_b);
    key_in    = key_b;
    cipher_in = ct_b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_after_handshake: out_valid/in_ready=%b want 01", {out_valid, in_ready});
    end
    want_lat = expected_latency(key_b);
    @(posedge clock);
    #1 in_valid = 1'b0;
    record_key(key_b);
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: in_ready/busy=%b want 01", {in_ready, busy});
    end
    await_result(1'b0, pt, lat);
    vectors++;
    if (pt !== want || lat != want_lat) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: got %h lat %0d want %h lat %0d", pt, lat, want, want_lat);
    end
    release_out();
  endtask

`ifdef AES_DEC_KEY_CACHE_EN
  task automatic test_key_cache();
    logic [127:0] pt;
    int lat;
    issue(C1_KEY, C1_CT);
    record_key(C1_KEY);
    await_result(1'b0, pt, lat);
    release_out();
    issue(C1_KEY, C1_CT);
    await_result(1'b0, pt, lat);
    vectors++;
    if (pt !== C1_PT || lat != 11) begin
      miscompares++;
      $display("[TB] FAIL cache_hit: got %h lat %0d want %h lat 11", pt, lat, C1_PT);
    end
    release_out();
    issue(B_KEY, B_CT);
    record_key(B_KEY);
    await_result(1'b0, pt, lat);
    vectors++;
    if (pt !== B_PT || lat != 21) begin
      miscompares++;
      $display("[TB] FAIL cache_miss: got %h lat %0d want %h lat 21", pt, lat, B_PT);
    end
    release_out();
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    build_tables();
    test_reset();
    test_fips("c1", C1_KEY, C1_CT, C1_PT);
    test_fips("appb", B_KEY, B_CT, B_PT);
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_ignored_input();
    test_back_to_back();
`ifdef AES_DEC_KEY_CACHE_EN
    test_key_cache();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
